// File: rtl/kyber_pkg.sv
// Shared types and arithmetic helpers for the Baby-Kyber key generator.
package kyber_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMP_A,
    ST_SAMP_S,
    ST_SAMP_E,
    ST_MAC,
    ST_RED,
    ST_EMIT,
    ST_DONE
  } kg_state_e;

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_T = 2'd1,
    SEL_S = 2'd2
  } kg_sel_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_2024;

  // Canonical residue in [0,q) for any signed input.
  function automatic logic [11:0] mod_q_canon(input logic signed [31:0] v,
                                              input int unsigned       q);
    logic signed [31:0] qs;
    logic signed [31:0] r;
    qs = $signed(q);
    r  = v % qs;
    if (r < 0) r = r + qs;
    return r[11:0];
  endfunction

  // Centred binomial sample: popcount(w[eta-1:0]) - popcount(w[2eta-1:eta]), mod q.
  function automatic logic [11:0] cbd_sample(input logic [7:0]  w,
                                             input int unsigned eta,
                                             input int unsigned q);
    logic signed [31:0] d;
    int unsigned        hi;
    d = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (b < eta) begin
        hi = b + eta;
        d  = d + $signed(32'(w[b[2:0]])) - $signed(32'(w[hi[2:0]]));
      end
    end
    return mod_q_canon(d, q);
  endfunction

endpackage

// File: rtl/kg_lfsr32.sv
// 32-bit Galois LFSR used as the on-chip random source (KG_INTERNAL_RNG_EN builds).
module kg_lfsr32
  import kyber_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [31:0] word
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign word = lfsr_q;

endmodule

// File: rtl/kyber_keygen_core.sv
// Baby-Kyber key generator: samples A, s, e, computes t = A*s + e in Z_Q[x]/(x^N+1)
// and streams A, t, s. Define KG_INTERNAL_RNG_EN to use the on-chip LFSR instead of rnd_*.
module kyber_keygen_core
  import kyber_pkg::*;
#(
  parameter  int unsigned K   = 2,
  parameter  int unsigned N   = 4,
  parameter  int unsigned Q   = 17,
  parameter  int unsigned ETA = 1,
  localparam int unsigned CW  = $clog2(Q)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          rnd_valid,
  output logic          rnd_ready,
  input  logic [31:0]   rnd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_data,
  output logic [1:0]    out_sel,
  output logic          out_last
);

  localparam int unsigned NA   = K * K * N;
  localparam int unsigned NV   = K * N;
  localparam int unsigned NTOT = NA + 2 * NV;
  localparam int unsigned AIW  = $clog2(NA);
  localparam int unsigned VIW  = $clog2(NV);
  localparam int unsigned IW   = $clog2(NTOT);
  localparam int unsigned KW   = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned NW   = $clog2(N);
  localparam int unsigned AW   = 2 * CW + $clog2(K * N) + 2;

  kg_state_e state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [KW-1:0]  i_q, i_d, j_q, j_d;
  logic [NW-1:0]  k_q, k_d, m_q, m_d;
  logic signed [AW-1:0] acc_q, acc_d;

  logic [CW-1:0] a_q [NA];
  logic [CW-1:0] s_q [NV];
  logic [CW-1:0] e_q [NV];
  logic [CW-1:0] t_q [NV];
  logic          a_we, s_we, e_we, t_we;

  logic [31:0]   rnd_word;
  logic          rnd_take;
  logic          samp_st;
  logic [31:0]   beat;
  logic [CW-1:0] a_val, cbd_val, red_val;
  logic          a_ok;
  logic [CW-1:0] a_cur, s_raw, e_cur;
  logic [NW-1:0] rot_idx;
  logic signed [CW:0]      a_s, s_cur;
  logic signed [2*CW+1:0]  prod;
  logic signed [31:0]      red_sum;
  logic                    unused_rnd_hi;

  assign samp_st = (state_q == ST_SAMP_A) || (state_q == ST_SAMP_S) || (state_q == ST_SAMP_E);

`ifdef KG_INTERNAL_RNG_EN
  logic unused_ext_rnd;
  assign unused_ext_rnd = rnd_valid ^ (^rnd_data);
  assign rnd_ready      = 1'b0;
  assign rnd_take       = samp_st;

  kg_lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (rnd_take),
    .word (rnd_word)
  );
`else
  assign rnd_ready = samp_st;
  assign rnd_take  = samp_st && rnd_valid;
  assign rnd_word  = rnd_data;
`endif

  assign unused_rnd_hi = ^rnd_word;
  assign beat          = 32'(idx_q);
  assign a_val         = rnd_word[CW-1:0];
  assign a_ok          = 32'(a_val) < Q;
  assign cbd_val       = CW'(cbd_sample(rnd_word[7:0], ETA, Q));

  // N is a power of two, so the negacyclic rotation index is a plain wrap.
  assign rot_idx = k_q - m_q;
  assign a_cur   = a_q[AIW'(32'(i_q) * NV + 32'(j_q) * N + 32'(m_q))];
  assign s_raw   = s_q[VIW'({j_q, rot_idx})];
  assign e_cur   = e_q[VIW'({i_q, k_q})];

  always_comb begin
    s_cur = $signed({1'b0, s_raw});
    if (32'(s_raw) > Q / 2) s_cur = $signed({1'b0, s_raw}) - $signed((CW+1)'(Q));
    a_s     = $signed({1'b0, a_cur});
    prod    = (2*CW+2)'(a_s) * (2*CW+2)'(s_cur);
    red_sum = 32'(acc_q) + $signed(32'(e_cur));
    red_val = CW'(mod_q_canon(red_sum, Q));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    m_d     = m_q;
    acc_d   = acc_q;
    a_we    = 1'b0;
    s_we    = 1'b0;
    e_we    = 1'b0;
    t_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SAMP_A;
          idx_d   = '0;
        end
      end
      ST_SAMP_A: begin
        if (rnd_take && a_ok) begin
          a_we = 1'b1;
          if (beat == NA - 1) begin
            state_d = ST_SAMP_S;
            idx_d   = '0;
          end else idx_d = idx_q + IW'(1);
        end
      end
      ST_SAMP_S: begin
        if (rnd_take) begin
          s_we = 1'b1;
          if (beat == NV - 1) begin
            state_d = ST_SAMP_E;
            idx_d   = '0;
          end else idx_d = idx_q + IW'(1);
        end
      end
      ST_SAMP_E: begin
        if (rnd_take) begin
          e_we = 1'b1;
          if (beat == NV - 1) begin
            state_d = ST_MAC;
            idx_d   = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            m_d     = '0;
            acc_d   = '0;
          end else idx_d = idx_q + IW'(1);
        end
      end
      ST_MAC: begin
        acc_d = (k_q < m_q) ? acc_q - AW'(prod) : acc_q + AW'(prod);
        if (m_q == NW'(N - 1)) begin
          m_d = '0;
          if (j_q == KW'(K - 1)) begin
            j_d     = '0;
            state_d = ST_RED;
          end else j_d = j_q + KW'(1);
        end else m_d = m_q + NW'(1);
      end
      ST_RED: begin
        t_we  = 1'b1;
        acc_d = '0;
        if (k_q == NW'(N - 1)) begin
          k_d = '0;
          if (i_q == KW'(K - 1)) begin
            i_d     = '0;
            idx_d   = '0;
            state_d = ST_EMIT;
          end else begin
            i_d     = i_q + KW'(1);
            state_d = ST_MAC;
          end
        end else begin
          k_d     = k_q + NW'(1);
          state_d = ST_MAC;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (beat == NTOT - 1) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '{default: '0};
      s_q <= '{default: '0};
      e_q <= '{default: '0};
      t_q <= '{default: '0};
    end else begin
      if (a_we) a_q[AIW'(beat)] <= a_val;
      if (s_we) s_q[VIW'(beat)] <= cbd_val;
      if (e_we) e_q[VIW'(beat)] <= cbd_val;
      if (t_we) t_q[VIW'({i_q, k_q})] <= red_val;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  // Output fields derive only from state and beat index, so they hold while stalled.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_sel   = SEL_A;
    out_last  = 1'b0;
    if (state_q == ST_EMIT) begin
      out_valid = 1'b1;
      if (beat < NA) begin
        out_sel  = SEL_A;
        out_data = a_q[AIW'(beat)];
      end else if (beat < NA + NV) begin
        out_sel  = SEL_T;
        out_data = t_q[VIW'(beat - NA)];
      end else begin
        out_sel  = SEL_S;
        out_data = s_q[VIW'(beat - NA - NV)];
      end
      out_last = (beat == NTOT - 1);
    end
  end

endmodule

// File: tb/tb_kyber_keygen_core.sv
// Directed bench for kyber_keygen_core (K=2, N=4, Q=17, ETA=1, external RNG).
module tb_kyber_keygen_core;

  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic        rnd_valid, rnd_ready;
  logic [31:0] rnd_data;
  logic        out_valid, out_ready, out_last;
  logic [4:0]  out_data;
  logic [1:0]  out_sel;

  kyber_keygen_core #(.K(2), .N(4), .Q(17), .ETA(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_data  (rnd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] words [64];
  logic [31:0] exp_d [32];
  logic [31:0] got_d [32];
  logic [1:0]  got_s [32];
  logic        got_l [32];
  int          nbeats, hs, last_cyc, done_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_vectors();
    for (int x = 0; x < 64; x++) words[x] = '0;
    for (int x = 0; x < 32; x++) exp_d[x] = '0;
  endtask

  task automatic run_gen(input int nwords, input bit stall);
    int          ptr, stall_cnt;
    bit          fin;
    logic [31:0] held;
    ptr = 0; nbeats = 0; hs = 0; last_cyc = -1; done_cyc = -1;
    fin = 1'b0; stall_cnt = 0; held = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      rnd_valid = (ptr < nwords);
      rnd_data  = rnd_valid ? words[ptr] : 32'h0;
      out_ready = !(stall && (nbeats == 5 || nbeats == 18) && stall_cnt < 3);
      #1;
      if (!out_ready) begin
        if (!out_valid) check("stall_valid", {31'b0, out_valid}, 32'd1);
        else if (stall_cnt == 0) held = 32'(out_data);
        else check($sformatf("stall_hold_b%0d", nbeats), 32'(out_data), held);
        stall_cnt++;
      end
      if (rnd_valid && rnd_ready) begin
        ptr++;
        hs++;
      end
      if (out_valid && out_ready) begin
        if (stall_cnt > 0) check($sformatf("stall_release_b%0d", nbeats), 32'(out_data), held);
        if (nbeats < 32) begin
          got_d[nbeats] = 32'(out_data);
          got_s[nbeats] = out_sel;
          got_l[nbeats] = out_last;
        end
        nbeats++;
        last_cyc  = cyc;
        stall_cnt = 0;
      end
      if (done) begin
        done_cyc = cyc;
        fin      = 1'b1;
      end
      @(negedge clk);
    end
    rnd_valid = 1'b0;
    out_ready = 1'b1;
    check("run_completed", {31'b0, fin}, 32'd1);
  endtask

  task automatic verify(input string name, input int exp_hs);
    logic [1:0] es;
    check({name, "_hs"}, hs, exp_hs);
    check({name, "_beats"}, nbeats, 32);
    for (int b = 0; b < 32 && b < nbeats; b++) begin
      es = (b < 16) ? 2'd0 : (b < 24) ? 2'd1 : 2'd2;
      check($sformatf("%s_data%0d", name, b), got_d[b], exp_d[b]);
      check($sformatf("%s_sel%0d", name, b), 32'(got_s[b]), 32'(es));
      check($sformatf("%s_last%0d", name, b), 32'(got_l[b]), (b == 31) ? 32'd1 : 32'd0);
    end
    check({name, "_done_lat"}, done_cyc, last_cyc + 1);
    #1;
    check({name, "_busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic load_t4(input bit neg_s00);
    clear_vectors();
    for (int x = 0; x < 16; x++) words[x] = 32'h1;
    for (int x = 0; x < 8; x++) words[16 + x] = (x % 4 == 0) ? 32'h1 : 32'h0;
    if (neg_s00) words[16] = 32'h2;
    for (int x = 0; x < 16; x++) exp_d[x] = 1;
    for (int x = 0; x < 8; x++) exp_d[16 + x] = neg_s00 ? 0 : 2;
    exp_d[24] = neg_s00 ? 16 : 1;
    exp_d[28] = 1;
  endtask

  initial begin
    int  ptr;
    bit  seen;
    rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd_data = '0; out_ready = 1'b1;

    // Reset state, then a start with no random words available.
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_rnd_ready", {31'b0, rnd_ready}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    rst = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    #1;
    check("start_busy", {31'b0, busy}, 32'd1);
    check("start_rnd_ready", {31'b0, rnd_ready}, 32'd1);
    repeat (5) @(negedge clk);
    #1;
    check("stall_rnd_ready", {31'b0, rnd_ready}, 32'd1);
    check("stall_out_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;

    // All-zero randomness.
    clear_vectors();
    run_gen(32, 1'b0);
    verify("zero", 32);

    // Rejection sampling of A.
    clear_vectors();
    words[0] = 32'h11; words[1] = 32'h1F; words[2] = 32'h03;
    exp_d[0] = 3;
    run_gen(34, 1'b0);
    verify("reject", 34);

    // A all ones, s = 1 at m=0: every t = 2; back-pressure mid-A and mid-t.
    load_t4(1'b0);
    run_gen(32, 1'b1);
    verify("ones", 32);

    // s[0][0] = -1 cancels the s[1] contribution.
    load_t4(1'b1);
    run_gen(32, 1'b0);
    verify("negs", 32);

    // Negacyclic wrap: x^3 * x = x^4 = -1.
    clear_vectors();
    words[3] = 32'h1; words[17] = 32'h1;
    exp_d[3] = 1; exp_d[16] = 16; exp_d[25] = 1;
    run_gen(32, 1'b0);
    verify("wrap", 32);

    // Reset during MAC aborts, then a rerun reproduces the expected stream.
    load_t4(1'b0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    ptr = 0;
    for (int c = 0; c < 500 && ptr < 32; c++) begin
      rnd_valid = 1'b1;
      rnd_data  = words[ptr];
      #1;
      if (rnd_ready) ptr++;
      @(negedge clk);
    end
    rnd_valid = 1'b0;
    check("abort_words", ptr, 32);
    repeat (10) @(negedge clk);
    #1;
    check("abort_busy_mac", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_rnd_ready", {31'b0, rnd_ready}, 32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      #1;
      if (out_valid || done || busy) seen = 1'b1;
    end
    check("abort_quiet", {31'b0, seen}, 32'd0);
    run_gen(32, 1'b0);
    verify("rerun", 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
